id_ex_operand_stage: RTL and testbench
======================================

# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage of the 16-bit CPU. It captures decoded instructions at the end of decode. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. It drives the execute-stage operands, including the `Shift_In`/`Shift_Val`/`Mode` inputs of the shifter. It also drives ALU operands and the control that travels down the pipe.

## Interface
Parameters:
- `DATA_W`, 16, datapath width
- `REG_W`, 4, register-index width (16 registers, R0 reads as zero)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `Stall`  in  1  hold EX register contents
- `Flush`  in  1  load a bubble instead of the ID instruction
- `ID_Valid`  in  1  ID holds a real instruction
- `ID_Opcode`  in  4  decoded opcode
- `ID_Rs`, `ID_Rt`, `ID_Rd`  in  REG_W each  source/destination indices
- `ID_Rs_Data`, `ID_Rt_Data`  in  DATA_W each  register-file read data
- `ID_Imm`  in  4  shift amount / short immediate
- `ID_RegWrite`  in  1  instruction writes `ID_Rd`
- `EXM_RegWrite`, `EXM_Rd`, `EXM_Result`  in  1/REG_W/DATA_W  EX/MEM forwarding source
- `MWB_RegWrite`, `MWB_Rd`, `MWB_Result`  in  1/REG_W/DATA_W  MEM/WB forwarding source
- `EX_Valid`, `EX_RegWrite`  out  1 each  registered control
- `EX_Opcode`  out  4; `EX_Rd`  out  REG_W
- `EX_Op_A`, `EX_Op_B`  out  DATA_W each  forwarded operands
- `Shift_In`  out  DATA_W; `Shift_Val`  out  4; `Mode`  out  1  shifter inputs
- `EX_Is_Shift`  out  1  current EX instruction is SLL/SRA
- `Fwd_A`, `Fwd_B`  out  2 each  forwarding select: 0 = register, 1 = MEM/WB, 2 = EX/MEM

## Operation
- EX register fields: valid, opcode, Rs, Rt, Rd, Rs_data, Rt_data, imm, regwrite.
- Load priority per edge: `rst` > `Flush` > `Stall` > normal load.
  - `rst` or `Flush`: all fields are 0. This is a bubble: `EX_Valid`=0, `EX_RegWrite`=0.
  - `Stall` (without `Flush`): all fields hold.
  - Normal load: fields take ID values. `ID_RegWrite` is gated by `ID_Valid`.
- `Stall` is raised only when the downstream stages are frozen too, so the forwarding sources stay coherent.
- Forwarding is combinational on the registered Rs/Rt, evaluated separately for A (Rs) and B (Rt):
  - If `EXM_RegWrite`, `EXM_Rd`≠0 and `EXM_Rd`==Rs, select `EXM_Result` (sel 2).
  - Else if `MWB_RegWrite`, `MWB_Rd`≠0 and `MWB_Rd`==Rs, select `MWB_Result` (sel 1).
  - Else select the registered data (sel 0).
  - If Rs==0 the operand is 0, regardless of the registered data or the forwarding sources.
- The register file provides write-through for same-cycle WB/ID reads. This block does not forward into ID.
- Shifter drive:
  - `EX_Is_Shift` = `EX_Valid` & (opcode==4'b0100 SLL | opcode==4'b0101 SRA).
  - `Shift_In` = `EX_Op_A` at all times.
  - `Shift_Val` = registered imm when `EX_Is_Shift`, else 0.
  - `Mode` = opcode[0] when `EX_Is_Shift`, else 0 (0 = SLL, 1 = SRA).
- `Fwd_A`/`Fwd_B` report the selects and are 0 whenever `EX_Valid`=0. On a bubble the forwarding result is not used by downstream logic.

## Timing
- Latency: ID inputs sampled at edge N appear on EX outputs after edge N, i.e. during cycle N+1.
- Forwarding, shifter drive and `Fwd_*` are combinational from the EX register and the `EXM_*`/`MWB_*` inputs, with zero added cycles.
- Reset values: every output is 0 after the reset edge (operands 0 because the registered Rs/Rt are 0). The exception is while `EXM_*`/`MWB_*` target a nonzero Rd: Rs=0 still forces 0, so every output is 0 in all cases.
- `Flush` and `Stall` asserted together: `Flush` wins and a bubble is loaded.
- Reset mid-stall: `rst` wins and the held instruction is discarded.
- Stall held for multiple cycles: outputs are constant as long as the forwarding sources are constant. Forwarded values track `EXM_Result`/`MWB_Result` every cycle.
- EX/MEM and MEM/WB both match: EX/MEM (the newer value) wins.

## Test plan
- Reset: `rst`=1 for 2 cycles with random ID inputs -> every output is 0. First edge after release with `ID_Valid`=1, SLL, Rs=3, imm=5, Rs_data=16'h0001 -> `EX_Is_Shift`=1, `Shift_In`=16'h0001, `Shift_Val`=5, `Mode`=0.
- Forwarding priority: EX has Rs=2, Rs_data=16'h1111; `EXM_*`=(1,2,16'hAAAA); `MWB_*`=(1,2,16'h5555) -> `EX_Op_A`=16'hAAAA, `Fwd_A`=2. Drop `EXM_RegWrite` -> `EX_Op_A`=16'h5555, `Fwd_A`=1.
- R0 handling: Rt=0 with `EXM_Rd`=0, `EXM_RegWrite`=1, `EXM_Result`=16'hFFFF -> `EX_Op_B`=0, `Fwd_B`=0.
- SRA via forward: opcode 0101, imm=4, Rs forwarded from MEM/WB as 16'h8000 -> `Mode`=1, `Shift_In`=16'h8000, `Shift_Val`=4.
- Stall/flush: load an ADD, then hold `Stall`=1 for 3 cycles while the ID inputs change -> EX outputs unchanged. Then `Stall`=1 and `Flush`=1 together -> next cycle `EX_Valid`=0, `EX_RegWrite`=0, `Shift_Val`=0.
- Non-shift opcode 0000 with imm=7 -> `EX_Is_Shift`=0, `Shift_Val`=0, `Mode`=0, `Shift_In`=`EX_Op_A`.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// Bus bundle for the ID/EX operand stage: decode-side capture, forwarding
// sources and the execute-side operands/control.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  logic              Stall;
  logic              Flush;
  logic              ID_Valid;
  logic [3:0]        ID_Opcode;
  logic [REG_W-1:0]  ID_Rs;
  logic [REG_W-1:0]  ID_Rt;
  logic [REG_W-1:0]  ID_Rd;
  logic [DATA_W-1:0] ID_Rs_Data;
  logic [DATA_W-1:0] ID_Rt_Data;
  logic [3:0]        ID_Imm;
  logic              ID_RegWrite;
  logic              EXM_RegWrite;
  logic [REG_W-1:0]  EXM_Rd;
  logic [DATA_W-1:0] EXM_Result;
  logic              MWB_RegWrite;
  logic [REG_W-1:0]  MWB_Rd;
  logic [DATA_W-1:0] MWB_Result;

  logic              EX_Valid;
  logic              EX_RegWrite;
  logic [3:0]        EX_Opcode;
  logic [REG_W-1:0]  EX_Rd;
  logic [DATA_W-1:0] EX_Op_A;
  logic [DATA_W-1:0] EX_Op_B;
  logic [DATA_W-1:0] Shift_In;
  logic [3:0]        Shift_Val;
  logic              Mode;
  logic              EX_Is_Shift;
  logic [1:0]        Fwd_A;
  logic [1:0]        Fwd_B;

  modport master (
    output Stall, Flush, ID_Valid, ID_Opcode, ID_Rs, ID_Rt, ID_Rd,
           ID_Rs_Data, ID_Rt_Data, ID_Imm, ID_RegWrite,
           EXM_RegWrite, EXM_Rd, EXM_Result, MWB_RegWrite, MWB_Rd, MWB_Result,
    input  EX_Valid, EX_RegWrite, EX_Opcode, EX_Rd, EX_Op_A, EX_Op_B,
           Shift_In, Shift_Val, Mode, EX_Is_Shift, Fwd_A, Fwd_B
  );

  modport slave (
    input  Stall, Flush, ID_Valid, ID_Opcode, ID_Rs, ID_Rt, ID_Rd,
           ID_Rs_Data, ID_Rt_Data, ID_Imm, ID_RegWrite,
           EXM_RegWrite, EXM_Rd, EXM_Result, MWB_RegWrite, MWB_Rd, MWB_Result,
    output EX_Valid, EX_RegWrite, EX_Opcode, EX_Rd, EX_Op_A, EX_Op_B,
           Shift_In, Shift_Val, Mode, EX_Is_Shift, Fwd_A, Fwd_B
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// shifter drive for the 16-bit CPU.
module id_ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input logic clk,
  input logic rst,
  id_ex_operand_stage_if.slave bus
);
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;

  logic              valid_reg;
  logic [3:0]        opcode_reg;
  logic [REG_W-1:0]  rs_reg;
  logic [REG_W-1:0]  rt_reg;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rs_data_reg;
  logic [DATA_W-1:0] rt_data_reg;
  logic [3:0]        imm_reg;
  logic              regwrite_reg;
  logic              is_shift;

  // A flush shares the reset path so a bubble is indistinguishable from reset.
  always_ff @(posedge clk) begin
    if (rst || bus.Flush) begin
      valid_reg    <= 1'b0;
      opcode_reg   <= '0;
      rs_reg       <= '0;
      rt_reg       <= '0;
      rd_reg       <= '0;
      rs_data_reg  <= '0;
      rt_data_reg  <= '0;
      imm_reg      <= '0;
      regwrite_reg <= 1'b0;
    end else if (!bus.Stall) begin
      valid_reg    <= bus.ID_Valid;
      opcode_reg   <= bus.ID_Opcode;
      rs_reg       <= bus.ID_Rs;
      rt_reg       <= bus.ID_Rt;
      rd_reg       <= bus.ID_Rd;
      rs_data_reg  <= bus.ID_Rs_Data;
      rt_data_reg  <= bus.ID_Rt_Data;
      imm_reg      <= bus.ID_Imm;
      regwrite_reg <= bus.ID_RegWrite & bus.ID_Valid;
    end
  end

  // Operand 0 is A (Rs), operand 1 is B (Rt); EX/MEM outranks MEM/WB as the newer value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic [REG_W-1:0]  src_idx;
    logic [DATA_W-1:0] src_data;
    logic [DATA_W-1:0] op_val;
    logic [1:0]        sel;

    assign src_idx  = (gi == 0) ? rs_reg : rt_reg;
    assign src_data = (gi == 0) ? rs_data_reg : rt_data_reg;

    always_comb begin
      sel    = 2'd0;
      op_val = src_data;
      if (src_idx == '0) begin
        op_val = '0;
      end else if (bus.EXM_RegWrite && (bus.EXM_Rd != '0) && (bus.EXM_Rd == src_idx)) begin
        sel    = 2'd2;
        op_val = bus.EXM_Result;
      end else if (bus.MWB_RegWrite && (bus.MWB_Rd != '0) && (bus.MWB_Rd == src_idx)) begin
        sel    = 2'd1;
        op_val = bus.MWB_Result;
      end
    end
  end

  assign is_shift = valid_reg & ((opcode_reg == OP_SLL) | (opcode_reg == OP_SRA));

  assign bus.EX_Valid    = valid_reg;
  assign bus.EX_RegWrite = regwrite_reg;
  assign bus.EX_Opcode   = opcode_reg;
  assign bus.EX_Rd       = rd_reg;
  assign bus.EX_Op_A     = g_opnd[0].op_val;
  assign bus.EX_Op_B     = g_opnd[1].op_val;
  assign bus.Fwd_A       = valid_reg ? g_opnd[0].sel : 2'd0;
  assign bus.Fwd_B       = valid_reg ? g_opnd[1].sel : 2'd0;
  assign bus.EX_Is_Shift = is_shift;
  assign bus.Shift_In    = g_opnd[0].op_val;
  assign bus.Shift_Val   = is_shift ? imm_reg : 4'd0;
  assign bus.Mode        = is_shift & opcode_reg[0];
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed vectors push expected
// EX outputs, a monitor pops and compares them on the falling edge.
module tb_id_ex_operand_stage;
  logic clk;
  logic rst;

  id_ex_operand_stage_if #(.DATA_W(16), .REG_W(4)) bus ();

  id_ex_operand_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        rw;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sin;
    logic [3:0]  sv;
    logic        mode;
    logic        is;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic ctrl(input logic r, input logic st, input logic fl);
    rst       = r;
    bus.Stall = st;
    bus.Flush = fl;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] op, input logic [3:0] rs,
                          input logic [3:0] rt, input logic [3:0] rd, input logic [15:0] rsd,
                          input logic [15:0] rtd, input logic [3:0] imm, input logic rw);
    bus.ID_Valid    = v;
    bus.ID_Opcode   = op;
    bus.ID_Rs       = rs;
    bus.ID_Rt       = rt;
    bus.ID_Rd       = rd;
    bus.ID_Rs_Data  = rsd;
    bus.ID_Rt_Data  = rtd;
    bus.ID_Imm      = imm;
    bus.ID_RegWrite = rw;
  endtask

  task automatic set_fwd(input logic erw, input logic [3:0] erd, input logic [15:0] eres,
                         input logic mrw, input logic [3:0] mrd, input logic [15:0] mres);
    bus.EXM_RegWrite = erw;
    bus.EXM_Rd       = erd;
    bus.EXM_Result   = eres;
    bus.MWB_RegWrite = mrw;
    bus.MWB_Rd       = mrd;
    bus.MWB_Result   = mres;
  endtask

  task automatic random_id();
    drive_id(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
  endtask

  // Advance past the edge; forwarding sources for this cycle are set afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic valid, input logic rw,
                            input logic [3:0] op, input logic [3:0] rd,
                            input logic [15:0] a, input logic [15:0] b, input logic [15:0] sin,
                            input logic [3:0] sv, input logic mode, input logic is,
                            input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.name = name; e.valid = valid; e.rw = rw; e.op = op; e.rd = rd;
    e.a = a; e.b = b; e.sin = sin; e.sv = sv; e.mode = mode; e.is = is;
    e.fa = fa; e.fb = fb;
    exp_q.push_back(e);
  endtask

  task automatic expect_zero(input string name);
    expect_out(name, 0, 0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 4'h0, 0, 0, 2'd0, 2'd0);
  endtask

  // Monitor: one comparison per presented cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (bus.EX_Valid !== e.valid || bus.EX_RegWrite !== e.rw || bus.EX_Opcode !== e.op ||
            bus.EX_Rd !== e.rd || bus.EX_Op_A !== e.a || bus.EX_Op_B !== e.b ||
            bus.Shift_In !== e.sin || bus.Shift_Val !== e.sv || bus.Mode !== e.mode ||
            bus.EX_Is_Shift !== e.is || bus.Fwd_A !== e.fa || bus.Fwd_B !== e.fb) begin
          n_fail++;
          $display("FAIL %s got v=%b rw=%b op=%h rd=%h a=%h b=%h sin=%h sv=%h m=%b is=%b fa=%0d fb=%0d exp v=%b rw=%b op=%h rd=%h a=%h b=%h sin=%h sv=%h m=%b is=%b fa=%0d fb=%0d",
                   e.name, bus.EX_Valid, bus.EX_RegWrite, bus.EX_Opcode, bus.EX_Rd,
                   bus.EX_Op_A, bus.EX_Op_B, bus.Shift_In, bus.Shift_Val, bus.Mode,
                   bus.EX_Is_Shift, bus.Fwd_A, bus.Fwd_B,
                   e.valid, e.rw, e.op, e.rd, e.a, e.b, e.sin, e.sv, e.mode, e.is, e.fa, e.fb);
        end else begin
          $display("check %s ok: a=%h b=%h fa=%0d fb=%0d", e.name, bus.EX_Op_A, bus.EX_Op_B,
                   bus.Fwd_A, bus.Fwd_B);
        end
      end
    end
  end

  initial begin
    ctrl(1, 0, 0);
    random_id();
    set_fwd(0, 4'h0, 16'h0, 0, 4'h0, 16'h0);

    // Reset with random ID and forwarding sources aimed at nonzero registers.
    tick(); random_id(); set_fwd(1, 4'h3, 16'hBEEF, 1, 4'h5, 16'h1234); expect_zero("reset1");
    tick(); set_fwd(1, 4'h3, 16'hBEEF, 1, 4'h5, 16'h1234); expect_zero("reset2");

    ctrl(0, 0, 0);
    drive_id(1, 4'b0100, 4'd3, 4'd0, 4'd1, 16'h0001, 16'h0000, 4'd5, 1);
    tick(); set_fwd(0, 4'h0, 16'h0, 0, 4'h0, 16'h0);
    expect_out("first_sll", 1, 1, 4'h4, 4'h1, 16'h0001, 16'h0, 16'h0001, 4'd5, 0, 1, 2'd0, 2'd0);

    drive_id(1, 4'b0010, 4'd2, 4'd0, 4'd4, 16'h1111, 16'h2222, 4'd0, 1);
    tick(); set_fwd(1, 4'h2, 16'hAAAA, 1, 4'h2, 16'h5555);
    expect_out("fwd_exm_wins", 1, 1, 4'h2, 4'h4, 16'hAAAA, 16'h0, 16'hAAAA, 4'd0, 0, 0, 2'd2, 2'd0);

    ctrl(0, 1, 0);
    drive_id(1, 4'b0111, 4'd9, 4'd9, 4'd9, 16'h9999, 16'h9999, 4'd9, 1);
    tick(); set_fwd(0, 4'h2, 16'hAAAA, 1, 4'h2, 16'h5555);
    expect_out("fwd_mwb", 1, 1, 4'h2, 4'h4, 16'h5555, 16'h0, 16'h5555, 4'd0, 0, 0, 2'd1, 2'd0);
    tick(); set_fwd(0, 4'h0, 16'h0, 0, 4'h0, 16'h0);
    expect_out("fwd_none", 1, 1, 4'h2, 4'h4, 16'h1111, 16'h0, 16'h1111, 4'd0, 0, 0, 2'd0, 2'd0);

    ctrl(0, 0, 0);
    drive_id(1, 4'b0000, 4'd6, 4'd0, 4'd7, 16'h0606, 16'h7777, 4'd7, 1);
    tick(); set_fwd(1, 4'h0, 16'hFFFF, 1, 4'h0, 16'hEEEE);
    expect_out("r0_nonshift", 1, 1, 4'h0, 4'h7, 16'h0606, 16'h0, 16'h0606, 4'd0, 0, 0, 2'd0, 2'd0);

    drive_id(1, 4'b0001, 4'd0, 4'd9, 4'd2, 16'h0001, 16'h0009, 4'd0, 0);
    tick(); set_fwd(1, 4'h9, 16'hC0DE, 1, 4'h9, 16'hDEAD);
    expect_out("fwd_b_exm", 1, 0, 4'h1, 4'h2, 16'h0, 16'hC0DE, 16'h0, 4'd0, 0, 0, 2'd0, 2'd2);

    drive_id(0, 4'b0100, 4'd3, 4'd4, 4'd5, 16'h3333, 16'h4444, 4'd9, 1);
    tick(); set_fwd(1, 4'h3, 16'hABCD, 0, 4'h0, 16'h0);
    expect_out("invalid_gate", 0, 0, 4'h4, 4'h5, 16'hABCD, 16'h4444, 16'hABCD, 4'd0, 0, 0, 2'd0, 2'd0);

    drive_id(1, 4'b0101, 4'd8, 4'd0, 4'd8, 16'h0000, 16'h0000, 4'd4, 1);
    tick(); set_fwd(1, 4'h9, 16'h1111, 1, 4'h8, 16'h8000);
    expect_out("sra_fwd", 1, 1, 4'h5, 4'h8, 16'h8000, 16'h0, 16'h8000, 4'd4, 1, 1, 2'd1, 2'd0);

    drive_id(1, 4'b0000, 4'd1, 4'd2, 4'd3, 16'h0011, 16'h0022, 4'd2, 1);
    tick(); set_fwd(0, 4'h0, 16'h0, 0, 4'h0, 16'h0);
    expect_out("add_load", 1, 1, 4'h0, 4'h3, 16'h0011, 16'h0022, 16'h0011, 4'd0, 0, 0, 2'd0, 2'd0);

    ctrl(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive_id(1, 4'(4 + i), 4'(10 + i), 4'(11 + i), 4'(12 + i), 16'(16'hF000 + i),
               16'(16'h0F00 + i), 4'(i), 1);
      tick(); set_fwd(0, 4'h0, 16'h0, 0, 4'h0, 16'h0);
      expect_out($sformatf("stall_hold%0d", i), 1, 1, 4'h0, 4'h3, 16'h0011, 16'h0022, 16'h0011,
                 4'd0, 0, 0, 2'd0, 2'd0);
    end

    ctrl(0, 1, 1);
    tick(); set_fwd(0, 4'h0, 16'h0, 0, 4'h0, 16'h0); expect_zero("stall_flush");

    ctrl(0, 0, 0);
    drive_id(1, 4'b0100, 4'd5, 4'd6, 4'd7, 16'h0005, 16'h0006, 4'd3, 1);
    tick(); set_fwd(0, 4'h0, 16'h0, 0, 4'h0, 16'h0);
    expect_out("sll_load", 1, 1, 4'h4, 4'h7, 16'h0005, 16'h0006, 16'h0005, 4'd3, 0, 1, 2'd0, 2'd0);

    ctrl(1, 1, 0);
    tick(); set_fwd(1, 4'h5, 16'h5A5A, 1, 4'h6, 16'h6B6B); expect_zero("reset_in_stall");

    ctrl(0, 0, 0);
    drive_id(1, 4'b0011, 4'd0, 4'd5, 4'd1, 16'h0000, 16'h0555, 4'd0, 1);
    tick(); set_fwd(1, 4'h5, 16'h0E0E, 1, 4'h5, 16'h0F0F);
    expect_out("fwd_b_both", 1, 1, 4'h3, 4'h1, 16'h0, 16'h0E0E, 16'h0, 4'd0, 0, 0, 2'd0, 2'd2);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
